imem_writer: RTL and testbench

IMEM_WRITER -- requirements
Module: imem_writer

---
 rtl/imem_writer.sv | 115 +++++++++++
 tb/tb_imem_writer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_writer.sv
// imem_writer: loads a 16-word instruction store through a valid/ready write
// port. A START pulse (re)starts the load at word 0; after the 16th accepted
// word the block parks in DONE with LOAD_DONE high until the next START.
//
// Optional feature macro: IMEM_WRITER_CLEAR_EN
//   defined   -> every START also zeroes all 16 stored words on that edge
//   undefined -> START leaves stored words intact (default build)
//
// Handshake: a word is transferred on a rising edge where WR_VALID and
// WR_READY are both high. WR_READY is high only in LOAD and only while START
// is low, so a beat presented together with START is never taken. WR_VALID
// may be dropped at any time with no penalty; there is no timeout.
module imem_writer #(
  parameter int n    = 16,
  parameter int logn = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              WR_VALID,
  input  logic [n-1:0]      WR_DATA,
  output logic              WR_READY,
  output logic [logn-1:0]   WR_PTR,
  output logic              BUSY,
  output logic              LOAD_DONE,
  output logic [16*n-1:0]   IMEM_WORDS,
  output logic [1:0]        DBG_STATE
);

  localparam int DEPTH = 16;
  localparam logic [logn-1:0] LAST_PTR = logn'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [n-1:0]   mem [DEPTH];
  logic           accept;
  logic           clear_all;

  // Handshake: ready only while loading and not being restarted this cycle
  assign WR_READY  = (state == LOAD) && !START;
  assign accept    = WR_READY && WR_VALID;
  assign BUSY      = (state == LOAD);
  assign DBG_STATE = state;

`ifdef IMEM_WRITER_CLEAR_EN
  assign clear_all = START;
`else
  assign clear_all = 1'b0;
`endif

  // Control FSM: state, write pointer and the registered completion flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      WR_PTR    <= '0;
      LOAD_DONE <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            state  <= LOAD;
            WR_PTR <= '0;
          end
        end
        LOAD: begin
          if (START) begin
            WR_PTR <= '0;
          end else if (WR_VALID) begin
            if (WR_PTR == LAST_PTR) begin
              state     <= DONE;
              WR_PTR    <= '0;
              LOAD_DONE <= 1'b1;
            end else begin
              WR_PTR <= WR_PTR + 1'b1;
            end
          end
        end
        DONE: begin
          if (START) begin
            state     <= LOAD;
            WR_PTR    <= '0;
            LOAD_DONE <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          WR_PTR    <= '0;
          LOAD_DONE <= 1'b0;
        end
      endcase
    end
  end

  // Word store: cleared by reset (and optionally by START), written on accept
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (clear_all) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (accept) begin
      mem[WR_PTR] <= WR_DATA;
    end
  end

  // Flatten the store: word k occupies [n*k+n-1 : n*k]
  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign IMEM_WORDS[n*g +: n] = mem[g];
  end

endmodule

// File: tb/tb_imem_writer.sv
// Testbench for imem_writer: directed load scenarios followed by randomized
// traffic, all checked against a word-array reference model.
module tb_imem_writer;

  localparam int N = 16;
  localparam int LOGN = 4;
  localparam int W = 256;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start = 1'b0;
  logic            wr_valid = 1'b0;
  logic [N-1:0]    wr_data = '0;
  logic            wr_ready;
  logic [LOGN-1:0] wr_ptr;
  logic            busy;
  logic            load_done;
  logic [16*N-1:0] imem_words;
  logic [1:0]      dbg_state;

  imem_writer #(.n(N), .logn(LOGN)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .WR_VALID(wr_valid),
    .WR_DATA(wr_data), .WR_READY(wr_ready), .WR_PTR(wr_ptr), .BUSY(busy),
    .LOAD_DONE(load_done), .IMEM_WORDS(imem_words), .DBG_STATE(dbg_state)
  );

  // Scoreboard counters and expected queue
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [W-1:0] got,
                          input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a plain word array, a "loading" flag, a "finished" flag
  // and the count of words written in the current load.
  logic [N-1:0] m_mem [16];
  bit m_loading;
  bit m_finished;
  int m_count;

  function automatic void model_reset();
    for (int k = 0; k < 16; k++) m_mem[k] = '0;
    m_loading = 0;
    m_finished = 0;
    m_count = 0;
  endfunction

  function automatic void model_edge(input bit s, input bit v, input logic [N-1:0] d);
    if (s) begin
`ifdef IMEM_WRITER_CLEAR_EN
      for (int k = 0; k < 16; k++) m_mem[k] = '0;
`endif
      m_loading = 1;
      m_finished = 0;
      m_count = 0;
    end else if (m_loading && v) begin
      m_mem[m_count] = d;
      m_count = m_count + 1;
      if (m_count == 16) begin
        m_loading = 0;
        m_finished = 1;
        m_count = 0;
      end
    end
  endfunction

  function automatic logic [W-1:0] model_words();
    logic [W-1:0] r = '0;
    for (int k = 0; k < 16; k++) r[16*k +: 16] = m_mem[k];
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, "_ptr"},   W'(wr_ptr), W'(m_count));
    check_eq({tag, "_busy"},  W'(busy), W'(m_loading));
    check_eq({tag, "_done"},  W'(load_done), W'(m_finished));
    check_eq({tag, "_ready"}, W'(wr_ready), W'(m_loading && !start));
    check_eq({tag, "_words"}, W'(imem_words), model_words());
  endtask

  // Driver: one clock cycle with the given inputs, outputs checked mid-cycle
  task automatic cycle(input string tag, input bit s, input bit v,
                       input logic [N-1:0] d);
    @(negedge clk);
    start = s;
    wr_valid = v;
    wr_data = d;
    #1 check_outputs(tag);
    @(posedge clk);
    model_edge(s, v, d);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    wr_valid = 1'b0;
    model_reset();
    #1 check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [W-1:0] exp_words;
  int cnt;
  int k;

  initial begin
    model_reset();
    #2 check_outputs("por");
    do_reset();

    // Back-to-back load 0x1000..0x100F; START issued right after reset release
    cycle("b2b_start", 1, 0, '0);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(W'(16'h1000 + i));
      cycle("b2b", 0, 1, 16'(16'h1000 + i));
    end
    cycle("b2b_after", 0, 1, 16'h5555);
    check_eq("b2b_done", W'(load_done), W'(1));
    check_eq("b2b_ready", W'(wr_ready), W'(0));
    for (int i = 0; i < 16; i++) begin
      exp_words = exp_q.pop_front();
      check_eq("b2b_word", W'(imem_words[16*i +: 16]), exp_words);
    end

    // Alternating valid: 32 cycles to finish
    cycle("alt_start", 1, 0, '0);
    cnt = 0;
    k = 0;
    while (!load_done && cnt < 100) begin
      cnt++;
      if (cnt % 2 == 0) begin
        cycle("alt", 0, 1, 16'(16'hA5A0 + k));
        k++;
      end else begin
        cycle("alt_idle", 0, 0, 16'($urandom_range(0, 65535)));
      end
    end
    check_eq("alt_cycles", W'(cnt), W'(32));
    for (int i = 0; i < 16; i++)
      check_eq("alt_word", W'(imem_words[16*i +: 16]), W'(16'hA5A0 + i));

    // Restart mid-load; beat coincident with START is dropped
    cycle("rs_start", 1, 0, '0);
    for (int i = 1; i <= 5; i++) cycle("rs_pre", 0, 1, 16'(i));
    cycle("rs_restart", 1, 1, 16'hBEEF);
    for (int i = 0; i < 16; i++) cycle("rs", 0, 1, 16'(16'hB000 + i));
    for (int i = 0; i < 16; i++)
      check_eq("rs_word", W'(imem_words[16*i +: 16]), W'(16'hB000 + i));

    // Asynchronous reset mid-load after 8 beats
    cycle("ar_start", 1, 0, '0);
    for (int i = 0; i < 8; i++) cycle("ar", 0, 1, 16'(16'h7700 + i));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("ar_state", W'(dbg_state), W'(0));
    check_eq("ar_ptr", W'(wr_ptr), W'(0));
    check_eq("ar_busy", W'(busy), W'(0));
    check_eq("ar_done", W'(load_done), W'(0));
    check_eq("ar_ready", W'(wr_ready), W'(0));
    check_eq("ar_words", W'(imem_words), W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Partial reload over a full 0xFFFF image
    cycle("pr_start", 1, 0, '0);
    for (int i = 0; i < 16; i++) cycle("pr_fill", 0, 1, 16'hFFFF);
    cycle("pr_restart", 1, 0, '0);
    cycle("pr_b0", 0, 1, 16'h0011);
    cycle("pr_b1", 0, 1, 16'h0022);
    cycle("pr_hold", 0, 0, '0);
    check_eq("pr_w0", W'(imem_words[15:0]), W'(16'h0011));
    check_eq("pr_w1", W'(imem_words[31:16]), W'(16'h0022));
    for (int i = 2; i < 16; i++)
`ifdef IMEM_WRITER_CLEAR_EN
      check_eq("pr_rest", W'(imem_words[16*i +: 16]), W'(16'h0000));
`else
      check_eq("pr_rest", W'(imem_words[16*i +: 16]), W'(16'hFFFF));
`endif

    // Writes ignored in IDLE and DONE
    do_reset();
    for (int i = 0; i < 3; i++) cycle("ig_idle", 0, 1, 16'hDEAD);
    check_eq("ig_idle_words", W'(imem_words), W'(0));
    cycle("ig_start", 1, 0, '0);
    for (int i = 0; i < 16; i++) cycle("ig_fill", 0, 1, 16'(16'h3000 + i));
    for (int i = 0; i < 3; i++) cycle("ig_done", 0, 1, 16'hDEAD);
    check_eq("ig_done_ptr", W'(wr_ptr), W'(0));
    for (int i = 0; i < 16; i++)
      check_eq("ig_done_word", W'(imem_words[16*i +: 16]), W'(16'h3000 + i));

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle("rnd", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            16'($urandom_range(0, 65535)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
